hazard_ctrl_unit: RTL

Pipeline hazard and stall controller for the 5-stage core. It sits beside the forwarding unit and decides, every cycle, whether the front end holds, whether a bubble is injected into ID/EX, whether IF/ID is flushed on a taken branch, and whether the whole pipeline freezes while a multi-cycle SRAM access in MEM completes. The block tracks the SRAM wait with a small FSM and timeout counter, and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_ctrl_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard and stall controller: RAW stall detection, branch flush,
// SRAM-wait freeze with timeout abort, and a saturating stall-cycle counter.
module hazard_ctrl_unit #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned REG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             branch_taken,
    output logic             freeze_front,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             freeze_all,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int unsigned       WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              mem_err_nxt;
    logic              freeze_mem_c;
    logic              exe_match, mem_match, raw_hazard;
    logic              stall_inc;

    // Source-register match against each producer stage
    assign exe_match = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
    assign mem_match = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));

    // With forwarding only a load in EXE stalls; without it any pending write does
    always_comb begin
        raw_hazard = 1'b0;
        if (fwd_en) begin
            raw_hazard = exe_wb_en && exe_mem_r_en && exe_match;
        end else begin
            raw_hazard = (exe_wb_en && exe_match) || (mem_wb_en && mem_match);
        end
    end

    // SRAM wait tracking; freeze_mem_c is the Mealy freeze request
    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        mem_err_nxt  = mem_err;
        freeze_mem_c = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !sram_ready) begin
                    freeze_mem_c = 1'b1;
                    wait_nxt     = '0;
                    state_nxt    = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (sram_ready) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    mem_err_nxt = 1'b1;
                    state_nxt   = RUN;
                end else begin
                    freeze_mem_c = 1'b1;
                    wait_nxt     = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Control outputs are held low for the whole reset assertion
    assign freeze_all   = rst & freeze_mem_c;
    assign flush_ifid   = rst & branch_taken & ~freeze_mem_c;
    assign freeze_front = rst & raw_hazard & id_valid & ~branch_taken & ~freeze_mem_c;
    assign bubble_idex  = freeze_front | flush_ifid;

    assign stall_inc = (freeze_all || freeze_front) && (stall_cnt != '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            mem_err  <= mem_err_nxt;
            if (stall_inc) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
endmodule
